// File: rtl/tx_arbiter.sv
// Arbitrates scheduler and prefetcher commands onto one TX engine and tracks reply ownership.
// Optional macro TX_ARB_ROUND_ROBIN_EN enables alternating grants; undefined gives fixed scheduler priority.
`ifndef TX_CMD_BITS
`define TX_CMD_BITS 16
`endif

module tx_arbiter #(
  parameter int NSHIFT      = 2,
  parameter int OWNER_DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    sched_cmd_valid,
  input  logic [`TX_CMD_BITS-1:0] sched_cmd,
  input  logic                    sched_reply_wanted,
  input  logic                    sched_reserve,
  input  logic                    pf_cmd_valid,
  input  logic [`TX_CMD_BITS-1:0] pf_cmd,
  input  logic [NSHIFT-1:0]       sched_tx_data,
  input  logic [NSHIFT-1:0]       pf_tx_data,
  output logic                    sched_tx_data_next,
  output logic                    pf_tx_data_next,
  output logic                    sched_started,
  output logic                    pf_started,
  output logic                    tx_command_valid,
  output logic [`TX_CMD_BITS-1:0] tx_command,
  output logic                    tx_reply_wanted,
  output logic [NSHIFT-1:0]       tx_data,
  input  logic                    tx_command_started,
  input  logic                    tx_data_next,
  input  logic                    tx_done,
  input  logic                    rx_started,
  input  logic                    rx_done,
  output logic                    rx_for_sched,
  output logic                    rx_for_pf
);

  localparam int CMDW = `TX_CMD_BITS;
  localparam int CW   = $clog2(OWNER_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, BUSY_SCHED, BUSY_PF} state_t;

  typedef struct packed {
    logic            vld;
    logic            is_sched;
    logic            reply;
    logic [CMDW-1:0] cmd;
  } cand_t;

  state_t                 state;
  cand_t                  cand;
  logic [OWNER_DEPTH-1:0] owner_q, owner_nxt;
  logic [CW-1:0]          cnt_q, wr_idx;
  logic                   full, pop, push, accept, slot_free;
  logic                   sched_elig, pf_elig, pick_pf;

  // Ownership only moves on rx_done; rx_started has no arbitration meaning.
  logic unused_rx_started;
  assign unused_rx_started = rx_started;

  assign full      = (cnt_q == CW'(OWNER_DEPTH));
  assign pop       = rx_done && (cnt_q != '0);
  // A slot freed by a same-cycle pop can be reused immediately.
  assign slot_free = !full || pop;

  assign sched_elig = sched_cmd_valid && (!sched_reply_wanted || slot_free);
  assign pf_elig    = pf_cmd_valid && !sched_reserve && slot_free;

`ifdef TX_ARB_ROUND_ROBIN_EN
  logic last_sched;

  assign pick_pf = pf_elig && (!sched_elig || last_sched);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       last_sched <= 1'b1;
    else if (accept) last_sched <= cand.is_sched;
  end
`else
  assign pick_pf = pf_elig && !sched_elig;
`endif

  always_comb begin
    cand = '0;
    if (state == IDLE && !reset) begin
      if (pick_pf) begin
        cand.vld      = 1'b1;
        cand.is_sched = 1'b0;
        cand.reply    = 1'b1;
        cand.cmd      = pf_cmd;
      end else if (sched_elig) begin
        cand.vld      = 1'b1;
        cand.is_sched = 1'b1;
        cand.reply    = sched_reply_wanted;
        cand.cmd      = sched_cmd;
      end
    end
  end

  assign accept = cand.vld && tx_command_started;
  assign push   = accept && cand.reply;

  // Owner FIFO is a shift register with the head at bit 0.
  always_comb begin
    owner_nxt = pop ? (owner_q >> 1) : owner_q;
    wr_idx    = pop ? (cnt_q - CW'(1)) : cnt_q;
    for (int i = 0; i < OWNER_DEPTH; i++)
      if (push && CW'(i) == wr_idx) owner_nxt[i] = cand.is_sched;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      owner_q <= '0;
      cnt_q   <= '0;
    end else begin
      owner_q <= owner_nxt;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: ;
      endcase
      case (state)
        IDLE:                if (accept) state <= cand.is_sched ? BUSY_SCHED : BUSY_PF;
        BUSY_SCHED, BUSY_PF: if (tx_done) state <= IDLE;
        default:             state <= IDLE;
      endcase
    end
  end

  always_comb begin
    tx_command_valid   = cand.vld;
    tx_command         = cand.cmd;
    tx_reply_wanted    = cand.reply;
    sched_started      = accept && cand.is_sched;
    pf_started         = accept && !cand.is_sched;
    tx_data            = '0;
    sched_tx_data_next = 1'b0;
    pf_tx_data_next    = 1'b0;
    if (!reset) begin
      if (state == BUSY_SCHED) begin
        tx_data            = sched_tx_data;
        sched_tx_data_next = tx_data_next;
      end else if (state == BUSY_PF) begin
        tx_data         = pf_tx_data;
        pf_tx_data_next = tx_data_next;
      end
    end
  end

  assign rx_for_sched = (cnt_q != '0) && owner_q[0];
  assign rx_for_pf    = (cnt_q != '0) && !owner_q[0];

endmodule
